// File: rtl/regfile_nrp.sv
// regfile_nrp -- parametrised register bank, one write port, two registered
// read ports with write-first bypass, and a hardware bulk-clear sequencer.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   clr      asynchronous active-high reset (clears array, outputs, FSM)
//   wen      write enable (honoured only while idle)
//   wsel     write address; addresses >= DEPTH are dropped
//   d        write data
//   rsel0/1  read addresses; addresses >= DEPTH read as zero
//   q0/q1    registered read data, one cycle after the address
//   clr_req  single-cycle pulse that starts a bulk clear
//   busy     high while the bulk clear runs (exactly DEPTH cycles)
//
// Build option: define REGFILE_NRP_ZERO_REG_EN to hardwire register 0 to
// zero (writes to it dropped, reads of it return 0 even on bypass).

module regfile_nrp #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wen,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel0,
    input  logic [AW-1:0]    rsel1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    input  logic             clr_req,
    output logic             busy
);

`ifdef REGFILE_NRP_ZERO_REG_EN
    localparam bit zero_reg_en = 1'b1;
`else
    localparam bit zero_reg_en = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] q_q [2];
    logic [WIDTH-1:0] q_d [2];
    logic [AW-1:0]    rsel [2];
    logic             last;
    logic             wr_en;

    // Address is backed by a real register (DEPTH need not be a power of 2).
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // Address 0 is the hardwired-zero register when that option is built in.
    function automatic logic zero_addr(input logic [AW-1:0] a);
        return zero_reg_en && (a == '0);
    endfunction

    assign rsel[0] = rsel0;
    assign rsel[1] = rsel1;
    assign q0      = q_q[0];
    assign q1      = q_q[1];

    assign last  = (ptr_q == AW'(DEPTH - 1));
    assign wr_en = !busy && wen && in_range(wsel) && !zero_addr(wsel);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // clr_req is only looked at in IDLE, so a request mid-clear cannot restart it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (last)    state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        case (state_q)
            CLEAR:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // ---------------- Array and pointer next-state ----------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_d = mem_q;
        ptr_d = '0;
        if (busy) begin
            mem_d[ptr_q] = '0;
            ptr_d        = last ? '0 : ptr_q + AW'(1);
        end else if (wr_en) begin
            // A write in the same cycle as clr_req still lands; the sweep
            // that follows clears it.
            mem_d[wsel] = d;
        end
    end

    // ---------------- Read ports ----------------
    // Bypass is write-first and only exists while idle (wr_en is low in
    // CLEAR), so a register being swept still reads its old value.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_d[p] = '0;
            if (in_range(rsel[p]) && !zero_addr(rsel[p])) begin
                if (wr_en && (wsel == rsel[p])) q_d[p] = d;
                else                            q_d[p] = mem_q[rsel[p]];
            end
        end
    end

    // NOTE: the array is reset because clr must zero every register at once;
    // this keeps it in flops rather than a RAM macro, which is intended here.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q <= '0;
            q_q   <= '{default: '0};
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            q_q   <= q_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_regfile_nrp.sv
module tb_regfile_nrp;

`ifdef REGFILE_NRP_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;

    // DUT A: default 8x8
    logic       wen = 0, clr_req = 0;
    logic [2:0] wsel = 0, rsel0 = 0, rsel1 = 0;
    logic [7:0] d = 0, q0, q1;
    logic       busy;

    // DUT B: 16 bits x 5 registers
    logic        b_wen = 0, b_clr_req = 0;
    logic [2:0]  b_wsel = 0, b_rsel0 = 0, b_rsel1 = 0;
    logic [15:0] b_d = 0, b_q0, b_q1;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    regfile_nrp dut_a (
        .clk(clk), .clr(clr), .wen(wen), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .q0(q0), .q1(q1),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_nrp #(.WIDTH(16), .DEPTH(5)) dut_b (
        .clk(clk), .clr(clr), .wen(b_wen), .wsel(b_wsel), .d(b_d),
        .rsel0(b_rsel0), .rsel1(b_rsel1), .q0(b_q0), .q1(b_q1),
        .clr_req(b_clr_req), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model of DUT A ----------------
    // The clear is tracked as "cycles left" plus a sweep index.
    logic [7:0] m_mem [8];
    int         m_left, m_ptr;
    logic [7:0] e_q0, e_q1;
    logic       e_busy;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_left = 0; m_ptr = 0;
        e_q0 = 8'h00; e_q1 = 8'h00; e_busy = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input int a, input bit idle);
        if (ZR && a == 0) return 8'h00;
        if (idle && wen && int'(wsel) == a && !(ZR && wsel == 0)) return d;
        return m_mem[a];
    endfunction

    task automatic model_step();
        bit idle;
        idle = (m_left == 0);
        e_q0 = m_read(int'(rsel0), idle);
        e_q1 = m_read(int'(rsel1), idle);
        if (idle) begin
            if (wen && !(ZR && wsel == 0)) m_mem[wsel] = d;
            if (clr_req) begin m_left = 8; m_ptr = 0; end
        end else begin
            m_mem[m_ptr] = 8'h00;
            m_ptr++;
            m_left--;
        end
        e_busy = (m_left != 0);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (clr) model_reset();
        else     model_step();
        @(negedge clk);
    endtask

    // Compare process: DUT A against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("q0_model",   32'(q0),   32'(e_q0));
            check("q1_model",   32'(q1),   32'(e_q1));
            check("busy_model", 32'(busy), 32'(e_busy));
        end
    end

    initial begin
        int n;
        model_reset();

        // Reset state, observed before any clock edge.
        #3;
        check("rst_q0", 32'(q0), 0);
        check("rst_q1", 32'(q1), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Write 1..7 to addresses 1..7, then read them back.
        for (int i = 1; i < 8; i++) begin
            wen = 1; wsel = 3'(i); d = 8'(i); rsel0 = 0; rsel1 = 0;
            cycle();
        end
        wen = 0;
        for (int i = 1; i < 8; i++) begin
            rsel0 = 3'(i); rsel1 = 3'(8 - i);
            cycle();
            check("fill_q0", 32'(q0), 32'(i));
            check("fill_q1", 32'(q1), 32'(8 - i));
        end

        // wen=0 must not write; then same-cycle write+read bypass on both ports.
        wen = 0; wsel = 3; d = 8'hA5; rsel0 = 3; rsel1 = 3;
        cycle();
        check("nowr_q0", 32'(q0), 32'h03);
        wen = 1; d = 8'h5A;
        cycle();
        check("byp_q0", 32'(q0), 32'h5A);
        check("byp_q1", 32'(q1), 32'h5A);
        wen = 0;
        cycle();
        check("stored_q0", 32'(q0), 32'h5A);

        // Fill with FF, then bulk clear; a write coincident with clr_req lands first.
        for (int i = 0; i < 8; i++) begin
            wen = 1; wsel = 3'(i); d = 8'hFF;
            cycle();
        end
        wen = 1; wsel = 2; d = 8'h11; rsel0 = 2; clr_req = 1;
        cycle();
        check("clrreq_byp_q0", 32'(q0), 32'h11);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            // Writes and repeated clr_req during the sweep must be ignored;
            // rsel0 follows the register being cleared at this edge.
            wen = 1; wsel = 3'(n); d = 8'h77; rsel0 = 3'(n - 1); rsel1 = 3'd7; clr_req = 1;
            cycle();
            if (n == 1) check("sweep_old_q0", 32'(q0), ZR ? 32'h00 : 32'hFF);
        end
        clr_req = 0; wen = 0;
        check("busy_len_a", 32'(n), 8);
        for (int i = 0; i < 8; i++) begin
            rsel0 = 3'(i); rsel1 = 3'(7 - i);
            cycle();
            check("cleared_q0", 32'(q0), 0);
        end

        // Asynchronous reset in the middle of a clear (ptr = 4).
        for (int i = 0; i < 8; i++) begin
            wen = 1; wsel = 3'(i); d = 8'hC3;
            cycle();
        end
        wen = 0; rsel0 = 7; rsel1 = 6; clr_req = 1;
        cycle();
        clr_req = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_abort_q0", 32'(q0), 32'hC3);
        check("pre_abort_busy", 32'(busy), 1);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_q0", 32'(q0), 0);
        check("abort_q1", 32'(q1), 0);
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsel0 = 3'(i); rsel1 = 3'(i);
            cycle();
            check("post_abort_q0", 32'(q0), 0);
        end

        // DUT B: DEPTH=5, WIDTH=16, out-of-range addresses and register 0.
        b_wen = 1; b_wsel = 6; b_d = 16'h1234;
        cycle();
        b_wsel = 4; b_d = 16'hABCD;
        cycle();
        b_wsel = 0; b_d = 16'hBEEF; b_rsel0 = 0;
        cycle();
        check("b_reg0_byp", 32'(b_q0), ZR ? 32'h0000 : 32'hBEEF);
        b_wen = 0; b_rsel0 = 7; b_rsel1 = 4;
        cycle();
        check("b_oor_q0", 32'(b_q0), 32'h0000);
        check("b_q1_reg4", 32'(b_q1), 32'hABCD);
        b_rsel0 = 6; b_rsel1 = 0;
        cycle();
        check("b_oor6_q0", 32'(b_q0), 32'h0000);
        check("b_reg0_rd", 32'(b_q1), ZR ? 32'h0000 : 32'hBEEF);
        for (int i = 1; i < 4; i++) begin
            b_rsel0 = 3'(i);
            cycle();
            check("b_no_alias", 32'(b_q0), 32'h0000);
        end
        b_wen = 1; b_wsel = 7; b_d = 16'hFFFF; b_rsel1 = 7;
        cycle();
        check("b_oor_byp_q1", 32'(b_q1), 32'h0000);
        b_wen = 0; b_clr_req = 1;
        cycle();
        b_clr_req = 0;
        n = 0;
        while (b_busy === 1'b1 && n < 20) begin
            n++;
            cycle();
        end
        check("busy_len_b", 32'(n), 5);
        for (int i = 0; i < 5; i++) begin
            b_rsel0 = 3'(i);
            cycle();
            check("b_cleared", 32'(b_q0), 32'h0000);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
